// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// FSM state and the instruction queue entry.
package fetch_pkg;

  typedef enum logic {
    RUN,
    ISR
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode.
// Registered storage, synchronous flush, occupancy count output.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pipelined imem reads, in-order queue,
// redirect flush and interrupt entry/exit.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  output logic        irq_ack,
  output logic [31:0] irq_epc,
  input  logic        irq_done
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   flush_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          take;
  logic          flush;
  logic          fire;
  logic          keep;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  entry;

  assign take     = !rst && state == RUN
                 && irq && !redirect;
  assign flush    = redirect || take;
  assign flush_pc = redirect ? redirect_pc : IRQ_VEC;

  // Credits cover words in flight plus words queued.
  assign used     = {1'b0, inflight} + {1'b0, count};
  assign imem_req = !rst && !flush
                 && used < (CW+1)'(QDEPTH);
  assign imem_addr = fetch_pc;
  assign fire     = imem_req && imem_gnt;

  assign keep     = imem_rvalid && drop == '0 && !flush;
  assign if_valid = count != '0;
  assign pop      = if_valid && id_ready && !flush;
  assign if_inst  = head.inst;
  assign if_pc    = head.pc;

  assign irq_ack  = take;
  assign irq_epc  = !take    ? '0 :
                    if_valid ? head.pc : rsp_pc;

  assign entry.inst = imem_rdata;
  assign entry.pc   = rsp_pc;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (keep),
    .din   (entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      state    <= RUN;
    end else begin
      inflight <= inflight + CW'(fire)
                - CW'(imem_rvalid);
      if (flush) begin
        drop     <= inflight - CW'(imem_rvalid);
        fetch_pc <= flush_pc;
        rsp_pc   <= flush_pc;
      end else begin
        if (fire) fetch_pc <= fetch_pc + PC_INC;
        if (imem_rvalid) begin
          if (drop != '0) drop <= drop - CW'(1);
          else rsp_pc <= rsp_pc + PC_INC;
        end
      end
      unique case (state)
        RUN: if (take) state <= ISR;
        ISR: if (irq_done) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ordered-latency memory model and a
// stream-level reference (next PC expected at decode).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        irq = 1'b0;
  logic        irq_ack;
  logic [31:0] irq_epc;
  logic        irq_done = 1'b0;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .IRQ_VEC  (IRQ_VEC),
    .PC_INC   (32'd1),
    .QDEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .irq_epc     (irq_epc),
    .irq_done    (irq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        memq[$];
  int          cyc = 0;
  int          lat = 1;
  int          checks = 0;
  int          failures = 0;
  int          ndeliv = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          in_isr = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: decode sees an unbroken PC stream from the last
  // reset/redirect/interrupt target; data is memf(pc).
  task automatic sample();
    bit exp_ack;
    @(negedge clk);
    if (rst) begin
      exp_pc = RESET_PC;
      in_isr = 1'b0;
    end else begin
      exp_ack = !in_isr && irq && !redirect;
      chk("irq_ack", {31'b0, irq_ack}, {31'b0, exp_ack});
      if (in_isr && irq_done) in_isr = 1'b0;
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (exp_ack) begin
        chk("irq_epc", irq_epc, exp_pc);
        exp_pc = IRQ_VEC;
        in_isr = 1'b1;
      end else if (if_valid && id_ready) begin
        chk("pop_pc", if_pc, exp_pc);
        chk("pop_inst", if_inst, memf(exp_pc));
        exp_pc = exp_pc + 32'd1;
        ndeliv++;
      end
      if (imem_req && imem_gnt)
        memq.push_back('{addr: imem_addr, due: cyc + lat});
    end
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (rst) begin
      memq.delete();
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(memq[0].addr);
      void'(memq.pop_front());
    end
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq = 1'b0;
    redirect = 1'b0;
    irq_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    sample();
    while (!if_valid && n < 30) begin
      advance();
      sample();
      n++;
    end
  endtask

  initial begin
    int n;
    int n0;
    bit found;

    // Reset values
    advance();
    sample();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_ack", {31'b0, irq_ack}, 32'd0);
    chk("rst_epc", irq_epc, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    advance();
    rst = 1'b0;

    // Back-to-back requests, 1-cycle memory
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("seq_req", {31'b0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr, RESET_PC + k);
      if (k < 2) begin
        chk("seq_novalid", {31'b0, if_valid}, 32'd0);
      end else begin
        chk("seq_valid", {31'b0, if_valid}, 32'd1);
        chk("seq_pc", if_pc, RESET_PC + k - 2);
      end
      advance();
    end

    // Decode stall: credits cap outstanding+queued at 4
    do_reset();
    id_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (imem_req && imem_gnt) n++;
      advance();
    end
    chk("stall_grants", n, 32'd4);
    sample();
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    chk("stall_pc", if_pc, RESET_PC);
    advance();
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("drain_valid", {31'b0, if_valid}, 32'd1);
      chk("drain_pc", if_pc, RESET_PC + k);
      advance();
    end

    // Redirect with three reads outstanding, 3-cycle memory
    lat = 3;
    do_reset();
    for (int k = 0; k < 3; k++) step();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    sample();
    chk("redir_noreq", {31'b0, imem_req}, 32'd0);
    advance();
    redirect = 1'b0;
    wait_valid();
    chk("redir_valid", {31'b0, if_valid}, 32'd1);
    chk("redir_pc", if_pc, 32'h40);
    chk("redir_inst", if_inst, memf(32'h40));
    advance();

    // Interrupt taken while head PC is 7
    lat = 1;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      sample();
      found = if_valid && id_ready && if_pc == 32'd6;
      advance();
    end
    id_ready = 1'b0;
    irq = 1'b1;
    sample();
    chk("irq_take", {31'b0, irq_ack}, 32'd1);
    chk("irq_epc7", irq_epc, 32'd7);
    advance();
    irq = 1'b0;
    id_ready = 1'b1;
    wait_valid();
    chk("isr_pc", if_pc, IRQ_VEC);
    advance();
    irq = 1'b1;
    sample();
    chk("isr_mask", {31'b0, irq_ack}, 32'd0);
    advance();
    irq = 1'b0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    irq = 1'b1;
    sample();
    chk("irq_retake", {31'b0, irq_ack}, 32'd1);
    advance();
    irq = 1'b0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;

    // Redirect beats irq; irq taken next cycle
    redirect = 1'b1;
    redirect_pc = 32'h80;
    irq = 1'b1;
    sample();
    chk("both_noack", {31'b0, irq_ack}, 32'd0);
    advance();
    redirect = 1'b0;
    sample();
    chk("late_ack", {31'b0, irq_ack}, 32'd1);
    chk("late_epc", irq_epc, 32'h80);
    advance();
    irq = 1'b0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;

    // Reset with reads in flight and words queued
    lat = 3;
    do_reset();
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    sample();
    chk("mid_valid", {31'b0, if_valid}, 32'd1);
    advance();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    chk("rst2_valid", {31'b0, if_valid}, 32'd0);
    chk("rst2_addr", imem_addr, RESET_PC);
    advance();
    id_ready = 1'b1;
    wait_valid();
    chk("rst2_pc", if_pc, RESET_PC);
    advance();

    // Randomized traffic against the stream reference
    for (int i = 0; i < 1500; i++) begin
      if (i % 128 == 0) lat = $urandom_range(1, 4);
      imem_gnt = $urandom_range(0, 9) < 7;
      id_ready = $urandom_range(0, 9) < 7;
      redirect = $urandom_range(0, 99) < 4;
      redirect_pc = ($urandom_range(0, 3) == 0)
                  ? 32'hFFFF_FFFD : $urandom;
      irq = $urandom_range(0, 99) < 5;
      irq_done = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 499) == 0;
      step();
    end

    // Quiet tail: the stream must keep flowing
    rst = 1'b0;
    redirect = 1'b0;
    irq = 1'b0;
    irq_done = 1'b1;
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    step();
    irq_done = 1'b0;
    n0 = ndeliv;
    for (int k = 0; k < 40; k++) step();
    chk("liveness", {31'b0, ndeliv > n0 + 20}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
